// File: rtl/ddr3_pg_arbiter.sv
// Round-robin arbiter that lends the DDR3 page transfer engine to one requester at a time,
// bounding each transfer with a timeout and keeping a saturating count of timed-out transfers.
module ddr3_pg_arbiter #(
   parameter int N_REQ     = 2,
   parameter int P_TIMEOUT = 4096
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cal_complete,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ-1:0]      req_optype,
   input  logic [28*N_REQ-1:0]   req_addr,
   output logic [N_REQ-1:0]      ack,
   output logic [N_REQ-1:0]      err,
   output logic [N_REQ-1:0]      grant,
   output logic                  pg_req,
   output logic                  pg_optype,
   output logic [27:0]           pg_req_addr,
   input  logic                  pg_ack,
   output logic                  busy,
   output logic [15:0]           timeout_cnt
);

   localparam int              IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [15:0]     TIMER_LAST = 16'(P_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [N_REQ-1:0]    grant_q, grant_d;
   logic [N_REQ-1:0]    ack_q, ack_d;
   logic [N_REQ-1:0]    err_q, err_d;
   logic                pg_req_q, pg_req_d;
   logic                pg_optype_q, pg_optype_d;
   logic [27:0]         pg_req_addr_q, pg_req_addr_d;
   logic                busy_q, busy_d;
   logic [15:0]         timer_q, timer_d;
   logic [15:0]         timeout_cnt_q, timeout_cnt_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;

   logic [27:0]         addr_arr [N_REQ];
   logic                sel_found;
   logic [IDX_W-1:0]    sel_idx;
   logic [N_REQ-1:0]    sel_onehot;
   logic [IDX_W:0]      cand_w;
   logic                start;
   logic                timer_hit;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = req_addr[28*gi +: 28];
   end

   // Search upward from the requester after the last winner, wrapping, so every pending
   // requester is reached within N_REQ grants.
   always_comb begin
      sel_found  = 1'b0;
      sel_idx    = '0;
      sel_onehot = '0;
      cand_w     = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         cand_w = {1'b0, rr_ptr_q} + (IDX_W+1)'(off);
         if (cand_w >= (IDX_W+1)'(N_REQ)) begin
            cand_w = cand_w - (IDX_W+1)'(N_REQ);
         end
         if (!sel_found && req[cand_w[IDX_W-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand_w[IDX_W-1:0];
         end
      end
      sel_onehot[sel_idx] = sel_found;
   end

   assign start     = cal_complete & sel_found;
   assign timer_hit = (timer_q == TIMER_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         grant_q       <= '0;
         ack_q         <= '0;
         err_q         <= '0;
         pg_req_q      <= 1'b0;
         pg_optype_q   <= 1'b0;
         pg_req_addr_q <= '0;
         busy_q        <= 1'b0;
         timer_q       <= '0;
         timeout_cnt_q <= '0;
         rr_ptr_q      <= PTR_RESET;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         ack_q         <= ack_d;
         err_q         <= err_d;
         pg_req_q      <= pg_req_d;
         pg_optype_q   <= pg_optype_d;
         pg_req_addr_q <= pg_req_addr_d;
         busy_q        <= busy_d;
         timer_q       <= timer_d;
         timeout_cnt_q <= timeout_cnt_d;
         rr_ptr_q      <= rr_ptr_d;
      end
   end

   // DONE waits for the owner to let go of req so a held request is not serviced twice.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_WAIT;
         ST_WAIT: if (pg_ack || timer_hit) state_d = ST_DONE;
         ST_DONE: if ((req & grant_q) == '0) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      grant_d       = grant_q;
      ack_d         = '0;
      err_d         = '0;
      pg_req_d      = pg_req_q;
      pg_optype_d   = pg_optype_q;
      pg_req_addr_d = pg_req_addr_q;
      busy_d        = 1'b0;
      timer_d       = timer_q;
      timeout_cnt_d = timeout_cnt_q;
      rr_ptr_d      = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (start) begin
               grant_d       = sel_onehot;
               pg_req_d      = 1'b1;
               pg_optype_d   = req_optype[sel_idx];
               pg_req_addr_d = addr_arr[sel_idx];
               rr_ptr_d      = sel_idx;
            end
         end
         // A completion on the timeout cycle counts as a normal completion.
         ST_WAIT: begin
            timer_d = timer_q + 16'd1;
            if (pg_ack) begin
               ack_d    = grant_q;
               pg_req_d = 1'b0;
            end else if (timer_hit) begin
               ack_d    = grant_q;
               err_d    = grant_q;
               pg_req_d = 1'b0;
               if (timeout_cnt_q != 16'hffff) begin
                  timeout_cnt_d = timeout_cnt_q + 16'd1;
               end
            end
         end
         ST_DONE: begin
            if ((req & grant_q) == '0) begin
               grant_d = '0;
            end
         end
         default: begin
            grant_d  = '0;
            pg_req_d = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   assign grant       = grant_q;
   assign ack         = ack_q;
   assign err         = err_q;
   assign pg_req      = pg_req_q;
   assign pg_optype   = pg_optype_q;
   assign pg_req_addr = pg_req_addr_q;
   assign busy        = busy_q;
   assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_ddr3_pg_arbiter.sv
// Bench for ddr3_pg_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model (round-robin by modulo search, completion time by min(ack delay, timeout)).
module tb_ddr3_pg_arbiter;

   localparam int N   = 2;
   localparam int PTO = 16;

   logic              clk;
   logic              rst_n;
   logic              cal_complete;
   logic [N-1:0]      req;
   logic [N-1:0]      req_optype;
   logic [28*N-1:0]   req_addr;
   logic [N-1:0]      ack;
   logic [N-1:0]      err;
   logic [N-1:0]      grant;
   logic              pg_req;
   logic              pg_optype;
   logic [27:0]       pg_req_addr;
   logic              pg_ack;
   logic              busy;
   logic [15:0]       timeout_cnt;

   int n_cmp;
   int n_fail;
   int model_last;
   int model_tc;

   ddr3_pg_arbiter #(.N_REQ(N), .P_TIMEOUT(PTO)) dut (
      .clk(clk), .rst_n(rst_n), .cal_complete(cal_complete),
      .req(req), .req_optype(req_optype), .req_addr(req_addr),
      .ack(ack), .err(err), .grant(grant),
      .pg_req(pg_req), .pg_optype(pg_optype), .pg_req_addr(pg_req_addr),
      .pg_ack(pg_ack), .busy(busy), .timeout_cnt(timeout_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Round-robin reference: first pending requester after the last winner, with wrap.
   function automatic int pick(input logic [N-1:0] r, input int last);
      for (int o = 1; o <= N; o++) begin
         int i;
         i = (last + o) % N;
         if (((r >> i) & N'(1)) != '0) return i;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; cal_complete = 1'b0; req = '0; req_optype = '0; req_addr = '0; pg_ack = 1'b0;
      tick(); tick();
      n_cmp++;
      if ({pg_req, pg_optype, pg_req_addr, ack, err, grant, busy, timeout_cnt} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got pg_req=%b addr=%h grant=%b ack=%b err=%b busy=%b tcnt=%0d want all zero",
                  pg_req, pg_req_addr, grant, ack, err, busy, timeout_cnt);
      end
      rst_n = 1'b1;
      model_last = N - 1;
      model_tc = 0;
      tick(); tick();
      n_cmp++;
      if ({pg_req, grant, busy, ack} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_idle: got pg_req=%b grant=%b busy=%b ack=%b want 0", pg_req, grant, busy, ack);
      end
   endtask

   task automatic test_basic();
      cal_complete = 1'b1;
      req_optype = 2'b01;
      req_addr = {28'hAAAAAAA, 28'h0001234};
      req = 2'b01;
      tick();
      model_last = pick(req, model_last);
      n_cmp++;
      if (grant !== 2'b01 || pg_req !== 1'b1 || pg_req_addr !== 28'h0001234 || pg_optype !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL basic_grant: got grant=%b pg_req=%b addr=%h op=%b want 01 1 0001234 1",
                  grant, pg_req, pg_req_addr, pg_optype);
      end
      req_addr = {28'h5555555, 28'h0ABCDEF};
      req_optype = 2'b10;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_cmp++;
         if (pg_req !== 1'b1 || ack !== 2'b00 || pg_req_addr !== 28'h0001234 || pg_optype !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL basic_hold: got pg_req=%b ack=%b addr=%h op=%b want 1 00 0001234 1",
                     pg_req, ack, pg_req_addr, pg_optype);
         end
      end
      pg_ack = 1'b1;
      tick();
      pg_ack = 1'b0;
      n_cmp++;
      if (ack !== 2'b01 || err !== 2'b00 || pg_req !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL basic_ack: got ack=%b err=%b pg_req=%b want 01 00 0", ack, err, pg_req);
      end
      tick();
      n_cmp++;
      if (ack !== 2'b00 || grant !== 2'b01 || busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL basic_done: got ack=%b grant=%b busy=%b want 00 01 1", ack, grant, busy);
      end
      req = 2'b00;
      tick();
      n_cmp++;
      if (grant !== 2'b00 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL basic_release: got grant=%b busy=%b want 00 0", grant, busy);
      end
   endtask

   task automatic test_round_robin();
      int exp;
      int w;
      logic [N-1:0] eg;
      req = 2'b11;
      for (int t = 0; t < 4; t++) begin
         exp = pick(req, model_last);
         eg = N'(1) << exp;
         w = 0;
         while (pg_req !== 1'b1 && w < 5) begin
            tick();
            w++;
         end
         model_last = exp;
         n_cmp++;
         if (pg_req !== 1'b1 || grant !== eg) begin
            n_fail++;
            $display("[TB] FAIL rr_grant%0d: got pg_req=%b grant=%b want 1 %b", t, pg_req, grant, eg);
         end
         tick();
         pg_ack = 1'b1;
         tick();
         pg_ack = 1'b0;
         n_cmp++;
         if (ack !== eg) begin
            n_fail++;
            $display("[TB] FAIL rr_ack%0d: got ack=%b want %b", t, ack, eg);
         end
         req = req & ~eg;
         tick();
         req = req | eg;
      end
      req = '0;
      tick();
   endtask

   task automatic test_timeout();
      int cnt;
      logic [N-1:0] eg;
      req = 2'b10;
      model_last = pick(req, model_last);
      eg = N'(1) << model_last;
      tick();
      cnt = 0;
      while (ack === '0 && cnt < 40) begin
         tick();
         cnt++;
      end
      model_tc++;
      n_cmp++;
      if (cnt != PTO || ack !== eg || err !== eg || pg_req !== 1'b0 || timeout_cnt !== 16'(model_tc)) begin
         n_fail++;
         $display("[TB] FAIL timeout: got cycles=%0d ack=%b err=%b pg_req=%b tcnt=%0d want %0d %b %b 0 %0d",
                  cnt, ack, err, pg_req, timeout_cnt, PTO, eg, eg, model_tc);
      end
      req = '0;
      tick();
      n_cmp++;
      if (busy !== 1'b0 || grant !== '0) begin
         n_fail++;
         $display("[TB] FAIL timeout_release: got busy=%b grant=%b want 0 00", busy, grant);
      end
   endtask

   task automatic test_cal_gate();
      cal_complete = 1'b0;
      req = 2'b01;
      repeat (3) tick();
      n_cmp++;
      if (busy !== 1'b0 || pg_req !== 1'b0 || grant !== '0) begin
         n_fail++;
         $display("[TB] FAIL cal_block: got busy=%b pg_req=%b grant=%b want 0 0 00", busy, pg_req, grant);
      end
      cal_complete = 1'b1;
      tick();
      model_last = pick(req, model_last);
      n_cmp++;
      if (grant !== 2'b01 || pg_req !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL cal_grant: got grant=%b pg_req=%b want 01 1", grant, pg_req);
      end
      cal_complete = 1'b0;
      tick(); tick();
      pg_ack = 1'b1;
      tick();
      pg_ack = 1'b0;
      n_cmp++;
      if (ack !== 2'b01 || err !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL cal_inflight: got ack=%b err=%b want 01 00", ack, err);
      end
      req = '0;
      tick();
      req = 2'b01;
      tick(); tick();
      n_cmp++;
      if (pg_req !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL cal_regrant_block: got pg_req=%b busy=%b want 0 0", pg_req, busy);
      end
      req = '0;
      cal_complete = 1'b1;
      tick();
   endtask

   task automatic test_random();
      int exp, d, exp_t, nh;
      bit exp_err, drop_early;
      logic [N-1:0] eg;
      logic [27:0] ea;
      logic eo;
      for (int t = 0; t < 40; t++) begin
         req = req | N'($urandom_range(0, (1 << N) - 1));
         if (req == '0) req = N'(1) << $urandom_range(0, N - 1);
         req_optype = N'($urandom);
         req_addr = (28*N)'({$urandom, $urandom});
         exp = pick(req, model_last);
         eg = N'(1) << exp;
         ea = 28'(req_addr >> (28 * exp));
         eo = 1'((req_optype >> exp) & N'(1));
         pg_ack = 1'($urandom);
         tick();
         pg_ack = 1'b0;
         model_last = exp;
         n_cmp++;
         if (grant !== eg || pg_req !== 1'b1 || pg_req_addr !== ea || pg_optype !== eo) begin
            n_fail++;
            $display("[TB] FAIL rand_grant%0d: got grant=%b pg_req=%b addr=%h op=%b want %b 1 %h %b",
                     t, grant, pg_req, pg_req_addr, pg_optype, eg, ea, eo);
         end
         req_addr = (28*N)'({$urandom, $urandom});
         req_optype = N'($urandom);
         drop_early = ($urandom_range(0, 3) == 0);
         if (drop_early) req = req & ~eg;
         d = $urandom_range(1, PTO + 6);
         exp_t = (d <= PTO) ? d : PTO;
         exp_err = (d > PTO);
         for (int c = 1; c <= exp_t; c++) begin
            if (c == d) pg_ack = 1'b1;
            tick();
            pg_ack = 1'b0;
            if (c < exp_t) begin
               n_cmp++;
               if (pg_req !== 1'b1 || ack !== '0 || pg_req_addr !== ea || pg_optype !== eo) begin
                  n_fail++;
                  $display("[TB] FAIL rand_wait%0d: got pg_req=%b ack=%b addr=%h op=%b want 1 00 %h %b",
                           t, pg_req, ack, pg_req_addr, pg_optype, ea, eo);
               end
            end
         end
         if (exp_err && model_tc < 65535) model_tc++;
         n_cmp++;
         if (ack !== eg || err !== (exp_err ? eg : N'(0)) || pg_req !== 1'b0 || timeout_cnt !== 16'(model_tc)) begin
            n_fail++;
            $display("[TB] FAIL rand_done%0d: got ack=%b err=%b pg_req=%b tcnt=%0d want %b %b 0 %0d (delay %0d)",
                     t, ack, err, pg_req, timeout_cnt, eg, exp_err ? eg : N'(0), model_tc, d);
         end
         if (!drop_early) begin
            nh = $urandom_range(0, 2);
            for (int h = 0; h < nh; h++) begin
               pg_ack = 1'($urandom);
               tick();
               pg_ack = 1'b0;
               n_cmp++;
               if (grant !== eg || ack !== '0 || busy !== 1'b1 || pg_req !== 1'b0) begin
                  n_fail++;
                  $display("[TB] FAIL rand_hold%0d: got grant=%b ack=%b busy=%b pg_req=%b want %b 00 1 0",
                           t, grant, ack, busy, pg_req, eg);
               end
            end
            req = req & ~eg;
         end
         tick();
         n_cmp++;
         if (grant !== '0 || busy !== 1'b0 || ack !== '0) begin
            n_fail++;
            $display("[TB] FAIL rand_idle%0d: got grant=%b busy=%b ack=%b want 00 0 00", t, grant, busy, ack);
         end
      end
      req = '0;
      tick();
   endtask

   task automatic test_reset_mid_wait();
      cal_complete = 1'b1;
      req = 2'b01;
      tick();
      tick(); tick();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (pg_req !== 1'b0 || ack !== '0 || busy !== 1'b0 || grant !== '0 || timeout_cnt !== '0) begin
         n_fail++;
         $display("[TB] FAIL rst_async: got pg_req=%b ack=%b busy=%b grant=%b tcnt=%0d want 0 00 0 00 0",
                  pg_req, ack, busy, grant, timeout_cnt);
      end
      tick(); tick();
      n_cmp++;
      if (ack !== '0 || err !== '0 || pg_req !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rst_hold: got ack=%b err=%b pg_req=%b want 00 00 0", ack, err, pg_req);
      end
      rst_n = 1'b1;
      model_last = N - 1;
      model_tc = 0;
      tick();
      model_last = pick(req, model_last);
      n_cmp++;
      if (grant !== 2'b01 || pg_req !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL rst_regrant: got grant=%b pg_req=%b want 01 1", grant, pg_req);
      end
      pg_ack = 1'b1;
      tick();
      pg_ack = 1'b0;
      n_cmp++;
      if (ack !== 2'b01 || err !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL rst_ack: got ack=%b err=%b want 01 00", ack, err);
      end
      for (int h = 0; h < 3; h++) begin
         pg_ack = 1'b1;
         tick();
         pg_ack = 1'b0;
         n_cmp++;
         if (grant !== 2'b01 || ack !== '0 || pg_req !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_held_done: got grant=%b ack=%b pg_req=%b busy=%b want 01 00 0 1",
                     grant, ack, pg_req, busy);
         end
      end
      req = '0;
      tick();
      pg_ack = 1'b1;
      tick();
      pg_ack = 1'b0;
      n_cmp++;
      if (grant !== '0 || busy !== 1'b0 || ack !== '0) begin
         n_fail++;
         $display("[TB] FAIL rst_release: got grant=%b busy=%b ack=%b want 00 0 00", grant, busy, ack);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      n_cmp = 0;
      n_fail = 0;
      test_reset();
      test_basic();
      test_round_robin();
      test_timeout();
      test_cal_gate();
      test_random();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
